// File: rtl/program_encoder.sv
// Instruction-memory loader: takes MIPS instruction fields one at a time, packs them
// into 32-bit words and writes them to consecutive addresses while holding the CPU.
module program_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   count
);

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      WRITE,
      DONE,
      ERROR
   } stateT;

   localparam logic [ADDR_W-1:0] baseAddr = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] lastAddr = '1;

   stateT             state;
   stateT             nextState;
   logic              lastReg;
   logic [31:0]       encoded;
   logic              supported;
   logic              handshake;
   logic              beginSession;
   logic              loadWord;
   logic              advance;

   // Opcode decode and field packing; LUI ignores rs, unknown opcodes are flagged.
   always_comb begin
      supported = 1'b1;
      encoded   = {in_op, in_rs, in_rt, in_imm};
      case (in_op)
         6'b000000: encoded = {in_op, in_rs, in_rt, in_rd, in_shamt, in_funct};
         6'b000010: encoded = {in_op, in_target};
         6'b001111: encoded = {in_op, 5'b00000, in_rt, in_imm};
         6'b000100, 6'b000101, 6'b001000, 6'b001010, 6'b001100,
         6'b001101, 6'b001110, 6'b100011, 6'b101011: encoded = {in_op, in_rs, in_rt, in_imm};
         default: supported = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and control strobes; the write strobe is also gated by reset so an
   // in-flight write is dropped the moment reset rises.
   always_comb begin
      nextState    = state;
      in_ready     = 1'b0;
      imem_we      = 1'b0;
      beginSession = 1'b0;
      loadWord     = 1'b0;
      advance      = 1'b0;
      handshake    = 1'b0;
      case (state)
         IDLE, DONE, ERROR: begin
            if (start) begin
               beginSession = 1'b1;
               nextState    = ACCEPT;
            end
         end
         ACCEPT: begin
            in_ready  = 1'b1;
            handshake = in_valid;
            if (handshake) begin
               if (supported) begin
                  loadWord  = 1'b1;
                  nextState = WRITE;
               end else begin
                  nextState = ERROR;
               end
            end
         end
         WRITE: begin
            imem_we = ~reset;
            advance = 1'b1;
            if (lastReg) begin
               nextState = DONE;
            end else if (imem_addr == lastAddr) begin
               nextState = ERROR;
            end else begin
               nextState = ACCEPT;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Session datapath: write address, word count and the registered word/last flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         imem_addr  <= baseAddr;
         count      <= '0;
         imem_wdata <= '0;
         lastReg    <= 1'b0;
      end else begin
         if (beginSession) begin
            imem_addr <= baseAddr;
            count     <= '0;
         end else if (advance) begin
            imem_addr <= imem_addr + 1'b1;
            count     <= count + 1'b1;
         end
         if (loadWord) begin
            imem_wdata <= encoded;
            lastReg    <= in_last;
         end
      end
   end

   assign done     = (state == DONE);
   assign error    = (state == ERROR);
   assign cpu_hold = (state != DONE);

endmodule

// File: doc/program_encoder.md
PROGRAM_ENCODER -- requirements
Module: program_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0: first word address written per session.
REQ-003 SHALL have clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have start  input  1  begins a load session (pulse).
REQ-006 SHALL have in_valid  input  1  instruction fields valid.
REQ-007 SHALL have in_ready  output  1  encoder accepts fields this cycle.
REQ-008 SHALL have in_op  input  6  opcode.
REQ-009 SHALL have in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
REQ-010 SHALL have in_funct  input  6  R-type function field.
REQ-011 SHALL have in_imm  input  16  I-type immediate.
REQ-012 SHALL have in_target  input  26  J-type target.
REQ-013 SHALL have in_last  input  1  marks final instruction of the session.
REQ-014 SHALL have imem_we  output  1  instruction-memory write strobe.
REQ-015 SHALL have imem_addr  output  ADDR_W  write word address.
REQ-016 SHALL have imem_wdata  output  32  encoded instruction word.
REQ-017 SHALL have cpu_hold  output  1  holds the processor in reset while loading.
REQ-018 SHALL have done, error  outputs  1 each  session status.
REQ-019 SHALL have count  output  ADDR_W+1  words written in current session.

Function
REQ-020 SHALL implement states IDLE, ACCEPT, WRITE, DONE, ERROR.
REQ-021 IDLE: in_ready=0; start -> ACCEPT, imem_addr=BASE_ADDR, count=0.
REQ-022 ACCEPT: in_ready=1; handshake = in_valid & in_ready.
REQ-023 On handshake with supported opcode: register encoded word and in_last, go WRITE next cycle.
REQ-024 Supported opcodes (libInstructions values): R 000000, J 000010, BEQ 000100, BNE 000101, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, XORI 001110, LUI 001111, LW 100011, SW 101011.
REQ-025 On handshake with any other opcode: no write, go ERROR.
REQ-026 Encoding R: {op,rs,rt,rd,shamt,funct}; J: {op,target}; LUI: {op,5'b0,rt,imm}; all other I-type: {op,rs,rt,imm}.
REQ-027 WRITE: imem_we=1 for exactly one cycle with registered imem_addr/imem_wdata; in_ready=0.
REQ-028 After WRITE: imem_addr increments by 1 (modulo 2^ADDR_W), count increments by 1.
REQ-029 After WRITE: if in_last -> DONE; else if written address was 2^ADDR_W-1 -> ERROR (overflow); else -> ACCEPT.
REQ-030 Latency: handshake in cycle n -> imem_we in cycle n+1; max throughput one word per 2 cycles.
REQ-031 DONE: done=1, cpu_hold=0, in_ready=0; start -> ACCEPT with addr=BASE_ADDR, count=0, done cleared.
REQ-032 ERROR: error=1, cpu_hold=1, in_ready=0; only start or reset exits; start behaves as in REQ-031.
REQ-033 cpu_hold SHALL be 1 in every state except DONE.
REQ-034 start SHALL be ignored in ACCEPT and WRITE.
REQ-035 imem_wdata SHALL be stable whenever imem_we=1; imem_we never asserted outside WRITE.

Reset
REQ-036 Reset asserted SHALL immediately force IDLE, imem_we=0, in_ready=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0, error=0, cpu_hold=1.
REQ-037 Reset during WRITE SHALL abort the write combinationally; no partial session state survives.

Verification
REQ-038 start; ADDI rs=1 rt=2 imm=0x0005 last=1 -> one write addr 0 data 0x20220005, then done=1, cpu_hold=0, count=1.
REQ-039 R rs=1 rt=2 rd=3 shamt=0 funct=0x20, then J target=0x0000010 last -> writes 0x00221820 @0, 0x08000010 @1, done.
REQ-040 in_op=0x3F on handshake -> no imem_we, error=1, cpu_hold=1; then start -> ACCEPT, error=0, addr=0.
REQ-041 ADDR_W=2, four non-last LW words -> writes @0..3, then error=1 (overflow), count=4.
REQ-042 LUI with rs=7 rt=4 imm=0x1234 -> data 0x3C041234 (rs zeroed).
REQ-043 reset asserted mid-WRITE -> imem_we falls same cycle, outputs at REQ-036 values; in_valid held low for a stretch in ACCEPT -> no writes.
